axi4_mem_ctrl: RTL and testbench

//  AXI4 slave front-end that sequences the single-port word memory (axi4_memory).

---
 rtl/axi4_mem_ctrl_pkg.sv | 18 +
 rtl/axi4_mem_ctrl_if.sv | 42 ++++
 rtl/axi4_mem_ctrl_rr_arb.sv | 24 ++
 rtl/axi4_mem_ctrl.sv | 154 +++++++++++++++
 tb/tb_axi4_mem_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi4_mem_ctrl_pkg.sv
// Shared constants and FSM state type for the AXI4 memory controller.
package axi4_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [2:0] SIZE_4B     = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        WR_RESP,
        RD_MEM,
        RD_WAIT,
        RD_DATA
    } state_t;

endpackage

// File: rtl/axi4_mem_ctrl_if.sv
// AXI4 write/read channel bundle between interconnect (master) and controller (slave).
interface axi4_mem_ctrl_if #(
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int DATA_WIDTH     = 32
);
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid, wdata, wlast, wvalid, bready,
               araddr, arlen, arsize, arburst, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid, wdata, wlast, wvalid, bready,
               araddr, arlen, arsize, arburst, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi4_mem_ctrl_rr_arb.sv
// Two-way round-robin grant between the AW and AR request channels.
module axi4_mem_rr_arb (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic req_wr,
    input  logic req_rd,
    output logic gnt_wr,
    output logic gnt_rd
);
    logic prio_wr;

    always_comb begin
        gnt_wr = en && req_wr && (!req_rd || prio_wr);
        gnt_rd = en && req_rd && (!req_wr || !prio_wr);
    end

    // Priority always moves to the channel that was not just served.
    always_ff @(posedge clk) begin
        if (!rst_n)      prio_wr <= 1'b1;
        else if (gnt_wr) prio_wr <= 1'b0;
        else if (gnt_rd) prio_wr <= 1'b1;
    end
endmodule

// File: rtl/axi4_mem_ctrl.sv
// AXI4 INCR-burst slave front-end sequencing one single-port word memory.
module axi4_mem_ctrl
    import axi4_mem_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 16,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int DEPTH          = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    axi4_mem_ctrl_if.slave            axi,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [MEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);
    localparam int WW = AXI_ADDR_WIDTH - 2;
    localparam logic [WW:0] DEPTH_W = (WW+1)'(DEPTH);

    state_t                    state_q, state_d;
    logic                      gnt_wr, gnt_rd, arb_en;
    logic [AXI_ADDR_WIDTH-1:0] req_addr;
    logic [7:0]                req_len;
    logic [2:0]                req_size;
    logic [1:0]                req_burst;
    logic [WW:0]               end_word;
    logic                      req_err;
    logic [MEM_ADDR_WIDTH-1:0] base_q;
    logic [7:0]                len_q, cnt_q;
    logic                      err_q, wl_err_q, last_beat, wl_bad;
    logic [1:0]                bresp_q, rresp_q;
    logic [DATA_WIDTH-1:0]     rdata_q;
    logic                      wready, bvalid, rvalid;

    assign arb_en = (state_q == IDLE);

    axi4_mem_rr_arb u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (arb_en),
        .req_wr (axi.awvalid),
        .req_rd (axi.arvalid),
        .gnt_wr (gnt_wr),
        .gnt_rd (gnt_rd)
    );

    always_comb begin
        if (gnt_wr) begin
            req_addr = axi.awaddr;  req_len   = axi.awlen;
            req_size = axi.awsize;  req_burst = axi.awburst;
        end else begin
            req_addr = axi.araddr;  req_len   = axi.arlen;
            req_size = axi.arsize;  req_burst = axi.arburst;
        end
        // Range check over the full word span so no start address can wrap into range.
        end_word = {1'b0, req_addr[AXI_ADDR_WIDTH-1:2]} + (WW+1)'(req_len);
        req_err  = (req_size != SIZE_4B) || (req_burst != BURST_INCR) ||
                   (req_addr[1:0] != 2'b00) || (end_word >= DEPTH_W);
    end

    assign last_beat = (cnt_q == len_q);
    assign wl_bad    = (axi.wlast != last_beat);

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        wready  = 1'b0;
        bvalid  = 1'b0;
        rvalid  = 1'b0;
        mem_en  = 1'b0;
        mem_we  = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_wr)      state_d = WR_DATA;
                else if (gnt_rd) state_d = RD_MEM;
            end
            WR_DATA: begin
                wready = 1'b1;
                if (axi.wvalid) begin
                    mem_en = !err_q;
                    mem_we = !err_q;
                    if (last_beat) state_d = WR_RESP;
                end
            end
            WR_RESP: begin
                bvalid = 1'b1;
                if (axi.bready) state_d = IDLE;
            end
            RD_MEM: begin
                mem_en  = !err_q;
                state_d = RD_WAIT;
            end
            RD_WAIT: state_d = RD_DATA;
            RD_DATA: begin
                rvalid = 1'b1;
                if (axi.rready) state_d = last_beat ? IDLE : RD_MEM;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_q   <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            wl_err_q <= 1'b0;
            bresp_q  <= '0;
            rresp_q  <= '0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (gnt_wr || gnt_rd) begin
                    base_q   <= req_addr[MEM_ADDR_WIDTH+1:2];
                    len_q    <= req_len;
                    cnt_q    <= '0;
                    err_q    <= req_err;
                    wl_err_q <= 1'b0;
                end
                WR_DATA: if (axi.wvalid) begin
                    cnt_q <= cnt_q + 8'd1;
                    if (wl_bad) wl_err_q <= 1'b1;
                    if (last_beat)
                        bresp_q <= (err_q || wl_err_q || wl_bad) ? RESP_SLVERR : RESP_OKAY;
                end
                RD_WAIT: begin
                    rdata_q <= err_q ? '0 : mem_rdata;
                    rresp_q <= err_q ? RESP_SLVERR : RESP_OKAY;
                end
                RD_DATA: if (axi.rready && !last_beat) cnt_q <= cnt_q + 8'd1;
                default: ;
            endcase
        end
    end

    assign axi.awready = gnt_wr;
    assign axi.arready = gnt_rd;
    assign axi.wready  = wready;
    assign axi.bvalid  = bvalid;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;
    assign axi.rlast   = (state_q == RD_DATA) && last_beat;
    assign mem_addr    = base_q + MEM_ADDR_WIDTH'(cnt_q);
    assign mem_wdata   = (state_q == WR_DATA) ? axi.wdata : '0;
endmodule

// File: tb/tb_axi4_mem_ctrl.sv
// Bench for axi4_mem_ctrl: directed scenarios plus randomized bursts against a word-array model.
module tb_axi4_mem_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    axi4_mem_ctrl_if #(.AXI_ADDR_WIDTH(16), .DATA_WIDTH(32)) axi ();

    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;

    axi4_mem_ctrl #(.DATA_WIDTH(32), .AXI_ADDR_WIDTH(16), .MEM_ADDR_WIDTH(10), .DEPTH(1024)) dut (
        .clk(clk), .rst_n(rst_n), .axi(axi), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct { int cyc; bit we; int addr; logic [31:0] data; } mem_rec_t;

    logic [31:0] mem_array [1024] = '{default: '0};
    logic [31:0] exp_mem   [1024] = '{default: '0};
    mem_rec_t    mem_log[$];
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    bit          prio_wr_m = 1'b1;
    logic [31:0] wdat [256];
    logic [31:0] got_data [256];
    logic [1:0]  got_resp [256];
    logic        got_last [256];
    bit          stall_changed;
    int          stall_mem;

    // Registered single-port memory; every strobe is also logged with its edge index.
    always @(posedge clk) begin
        if (mem_en === 1'b1) begin
            mem_log.push_back('{cyc: cyc, we: mem_we, addr: int'(mem_addr), data: mem_wdata});
            if (mem_we) mem_array[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_array[mem_addr];
        end
        cyc <= cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    function automatic bit model_err(input logic [15:0] addr, input int len,
                                     input logic [2:0] size, input logic [1:0] burst);
        return (size != 3'b010) || (burst != 2'b01) || (addr % 4 != 0) ||
               (int'(addr) / 4 + len >= 1024);
    endfunction

    task automatic clear_inputs();
        axi.awaddr = '0; axi.awlen = '0; axi.awsize = 3'b010; axi.awburst = 2'b01; axi.awvalid = 0;
        axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'b010; axi.arburst = 2'b01; axi.arvalid = 0;
        axi.wdata = '0; axi.wlast = 0; axi.wvalid = 0; axi.bready = 0; axi.rready = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
        prio_wr_m = 1'b1;
    endtask

    task automatic send_aw(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, output int acc);
        int n = 0;
        axi.awaddr = addr; axi.awlen = len; axi.awsize = size; axi.awburst = burst; axi.awvalid = 1;
        #1;
        while (axi.awready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        acc = cyc;
        if (n >= 50) begin checks++; failures++; $display("FAIL aw_timeout: awready=%b after 50 cycles, required 1", axi.awready); end
        @(negedge clk);
        axi.awvalid = 0;
        prio_wr_m = 1'b0;
    endtask

    task automatic send_ar(input logic [15:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int n = 0;
        axi.araddr = addr; axi.arlen = len; axi.arsize = size; axi.arburst = burst; axi.arvalid = 1;
        #1;
        while (axi.arready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin checks++; failures++; $display("FAIL ar_timeout: arready=%b after 50 cycles, required 1", axi.arready); end
        @(negedge clk);
        axi.arvalid = 0;
        prio_wr_m = 1'b1;
    endtask

    task automatic send_w(input int len, input int wl_at, output int last_cyc);
        int n;
        last_cyc = 0;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            axi.wvalid = 1; axi.wdata = wdat[b]; axi.wlast = (b == wl_at);
            #1;
            while (axi.wready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
            if (n >= 50) begin checks++; failures++; $display("FAIL w_timeout: beat %0d wready=%b, required 1", b, axi.wready); end
            last_cyc = cyc;
            @(negedge clk);
        end
        axi.wvalid = 0; axi.wlast = 0;
    endtask

    task automatic get_b(output logic [1:0] resp, output int bc);
        int n = 0;
        axi.bready = 1;
        #1;
        while (axi.bvalid !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
        if (n >= 50) begin checks++; failures++; $display("FAIL b_timeout: bvalid=%b after 50 cycles, required 1", axi.bvalid); end
        resp = axi.bresp;
        bc = cyc;
        @(negedge clk);
        axi.bready = 0;
    endtask

    task automatic get_r(input int len, input int stall_beat, input int stall_n);
        int n;
        int m;
        stall_changed = 0;
        stall_mem = 0;
        for (int b = 0; b <= len; b++) begin
            n = 0;
            #1;
            while (axi.rvalid !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
            if (n >= 50) begin checks++; failures++; $display("FAIL r_timeout: beat %0d rvalid=%b, required 1", b, axi.rvalid); return; end
            got_data[b] = axi.rdata; got_resp[b] = axi.rresp; got_last[b] = axi.rlast;
            if (b == stall_beat) begin
                m = mem_log.size();
                repeat (stall_n) begin
                    @(negedge clk); #1;
                    if (axi.rvalid !== 1'b1 || axi.rdata !== got_data[b] || axi.rresp !== got_resp[b] ||
                        axi.rlast !== got_last[b]) stall_changed = 1;
                end
                stall_mem = mem_log.size() - m;
            end
            axi.rready = 1;
            @(negedge clk);
            axi.rready = 0;
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++; if ({axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid} !== 5'b0) begin failures++; $display("FAIL reset_handshake: got %b required 00000", {axi.awready, axi.arready, axi.wready, axi.bvalid, axi.rvalid}); end
        checks++; if ({mem_en, mem_we} !== 2'b00) begin failures++; $display("FAIL reset_mem_strobe: got %b required 00", {mem_en, mem_we}); end
        checks++; if ({axi.bresp, axi.rresp} !== 4'b0) begin failures++; $display("FAIL reset_resp: got %b required 0000", {axi.bresp, axi.rresp}); end
        checks++; if (axi.rdata !== 32'h0 || mem_addr !== 10'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL reset_data: rdata=%h mem_addr=%h mem_wdata=%h required all 0", axi.rdata, mem_addr, mem_wdata); end
        @(negedge clk);
    endtask

    task automatic test_write_basic();
        int m0, ac, lc, bc;
        logic [1:0] resp;
        m0 = mem_log.size();
        for (int b = 0; b < 4; b++) wdat[b] = 32'hA0 + b;
        send_aw(16'h0010, 8'd3, 3'b010, 2'b01, ac);
        send_w(3, 3, lc);
        get_b(resp, bc);
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL wr_basic_bresp: got %b required 00", resp); end
        checks++; if (bc !== lc + 1) begin failures++; $display("FAIL wr_basic_b_latency: bvalid at edge %0d required %0d", bc, lc + 1); end
        checks++; if (mem_log.size() - m0 != 4) begin failures++; $display("FAIL wr_basic_count: got %0d writes required 4", mem_log.size() - m0); end
        else begin
            checks++; if (mem_log[m0].cyc <= ac) begin failures++; $display("FAIL wr_basic_first_latency: first write edge %0d required > %0d", mem_log[m0].cyc, ac); end
            for (int b = 0; b < 4; b++) begin
                checks++;
                if (mem_log[m0+b].we !== 1'b1 || mem_log[m0+b].addr != 4 + b || mem_log[m0+b].data !== wdat[b]) begin
                    failures++; $display("FAIL wr_basic_beat%0d: we=%b idx=%0d data=%h required we=1 idx=%0d data=%h", b, mem_log[m0+b].we, mem_log[m0+b].addr, mem_log[m0+b].data, 4 + b, wdat[b]);
                end
            end
        end
        for (int b = 0; b < 4; b++) exp_mem[4+b] = wdat[b];
    endtask

    task automatic test_read_basic();
        int m0;
        m0 = mem_log.size();
        send_ar(16'h0010, 8'd3, 3'b010, 2'b01);
        get_r(3, 1, 5);
        for (int b = 0; b < 4; b++) begin
            checks++;
            if (got_data[b] !== exp_mem[4+b] || got_resp[b] !== 2'b00 || got_last[b] !== (b == 3)) begin
                failures++; $display("FAIL rd_basic_beat%0d: data=%h resp=%b last=%b required data=%h resp=00 last=%b", b, got_data[b], got_resp[b], got_last[b], exp_mem[4+b], b == 3);
            end
        end
        checks++; if (stall_changed !== 1'b0) begin failures++; $display("FAIL rd_stall_stable: outputs changed during stall, required stable"); end
        checks++; if (stall_mem != 0) begin failures++; $display("FAIL rd_stall_mem: got %0d strobes during stall required 0", stall_mem); end
        checks++; if (mem_log.size() - m0 != 4) begin failures++; $display("FAIL rd_basic_count: got %0d strobes required 4", mem_log.size() - m0); end
    endtask

    task automatic test_arbitration();
        bit exp_wr;
        int lc, bc;
        logic [1:0] resp;
        do_reset();
        for (int round = 0; round < 2; round++) begin
            @(negedge clk);
            axi.awaddr = 16'h0020; axi.awlen = 0; axi.araddr = 16'h0020; axi.arlen = 0;
            axi.awvalid = 1; axi.arvalid = 1;
            #1;
            exp_wr = prio_wr_m;
            checks++; if (axi.awready !== exp_wr || axi.arready !== !exp_wr) begin failures++; $display("FAIL arb_round%0d: awready=%b arready=%b required %b %b", round, axi.awready, axi.arready, exp_wr, !exp_wr); end
            @(negedge clk);
            axi.awvalid = 0; axi.arvalid = 0;
            prio_wr_m = !exp_wr;
            if (exp_wr) begin
                wdat[0] = 32'hC0DE_0000 + round;
                send_w(0, 0, lc);
                get_b(resp, bc);
                checks++; if (resp !== 2'b00) begin failures++; $display("FAIL arb_wr_bresp: got %b required 00", resp); end
                exp_mem[8] = wdat[0];
            end else begin
                get_r(0, -1, 0);
                checks++; if (got_data[0] !== exp_mem[8]) begin failures++; $display("FAIL arb_rd_data: got %h required %h", got_data[0], exp_mem[8]); end
            end
        end
    endtask

    task automatic test_error();
        int m0, ac, lc, bc;
        logic [1:0] resp;
        m0 = mem_log.size();
        wdat[0] = 32'h1111_1111; wdat[1] = 32'h2222_2222;
        send_aw(16'h0FFC, 8'd1, 3'b010, 2'b01, ac);
        send_w(1, 1, lc);
        get_b(resp, bc);
        checks++; if (resp !== 2'b10) begin failures++; $display("FAIL err_range_bresp: got %b required 10", resp); end
        checks++; if (mem_log.size() != m0) begin failures++; $display("FAIL err_range_mem: got %0d strobes required 0", mem_log.size() - m0); end
        send_ar(16'h0010, 8'd0, 3'b011, 2'b01);
        get_r(0, -1, 0);
        checks++; if (got_resp[0] !== 2'b10 || got_data[0] !== 32'h0 || got_last[0] !== 1'b1) begin failures++; $display("FAIL err_size_read: resp=%b data=%h last=%b required 10 00000000 1", got_resp[0], got_data[0], got_last[0]); end
        checks++; if (mem_log.size() != m0) begin failures++; $display("FAIL err_size_mem: got %0d strobes required 0", mem_log.size() - m0); end
    endtask

    task automatic test_wlast_err();
        int ac, lc, bc;
        logic [1:0] resp;
        for (int b = 0; b < 4; b++) wdat[b] = 32'h5500 + b;
        send_aw(16'h0040, 8'd3, 3'b010, 2'b01, ac);
        send_w(3, 1, lc);
        get_b(resp, bc);
        checks++; if (resp !== 2'b10) begin failures++; $display("FAIL wlast_bresp: got %b required 10", resp); end
        checks++; if (bc !== lc + 1) begin failures++; $display("FAIL wlast_b_timing: bvalid at edge %0d required %0d", bc, lc + 1); end
    endtask

    task automatic test_reset_mid();
        int ac, lc, bc;
        logic [1:0] resp;
        bit seen_b = 0;
        send_aw(16'h0080, 8'd3, 3'b010, 2'b01, ac);
        for (int b = 0; b < 2; b++) begin
            axi.wvalid = 1; axi.wdata = 32'hDEAD_0000 + b; axi.wlast = 0;
            @(negedge clk);
        end
        axi.wdata = 32'hDEAD_0002;
        rst_n = 0;
        @(negedge clk);
        #1;
        checks++; if ({axi.wready, axi.bvalid, axi.rvalid, mem_en, mem_we} !== 5'b0) begin failures++; $display("FAIL midrst_outputs: wready,bvalid,rvalid,mem_en,mem_we=%b required 00000", {axi.wready, axi.bvalid, axi.rvalid, mem_en, mem_we}); end
        checks++; if (mem_addr !== 10'h0 || axi.bresp !== 2'b00) begin failures++; $display("FAIL midrst_regs: mem_addr=%h bresp=%b required 0 00", mem_addr, axi.bresp); end
        axi.wvalid = 0;
        @(negedge clk);
        rst_n = 1;
        prio_wr_m = 1'b1;
        repeat (4) begin @(negedge clk); #1; if (axi.bvalid === 1'b1) seen_b = 1; end
        checks++; if (seen_b) begin failures++; $display("FAIL midrst_no_b: bvalid seen after aborted burst, required none"); end
        @(negedge clk);
        for (int b = 0; b < 4; b++) wdat[b] = 32'h7700 + b;
        send_aw(16'h0080, 8'd3, 3'b010, 2'b01, ac);
        send_w(3, 3, lc);
        get_b(resp, bc);
        checks++; if (resp !== 2'b00) begin failures++; $display("FAIL midrst_next_bresp: got %b required 00", resp); end
        for (int b = 0; b < 4; b++) exp_mem[32+b] = wdat[b];
        send_ar(16'h0080, 8'd3, 3'b010, 2'b01);
        get_r(3, -1, 0);
        for (int b = 0; b < 4; b++) begin
            checks++; if (got_data[b] !== exp_mem[32+b]) begin failures++; $display("FAIL midrst_readback%0d: got %h required %h", b, got_data[b], exp_mem[32+b]); end
        end
    endtask

    task automatic test_random();
        int kind, len, word, m0, ac, lc, bc, nexp;
        logic [15:0] addr;
        logic [2:0] size;
        logic [1:0] burst, resp, eresp;
        bit is_wr, err;
        for (int t = 0; t < 30; t++) begin
            kind = $urandom_range(0, 7); len = $urandom_range(0, 7); is_wr = 1'($urandom_range(0, 1));
            size = 3'b010; burst = 2'b01;
            word = 64 + $urandom_range(0, 1024 - 64 - 8);
            addr = 16'(word * 4);
            case (kind)
                0: size = ($urandom_range(0, 1) == 0) ? 3'b001 : 3'b011;
                1: burst = ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b10;
                2: addr = addr | 16'($urandom_range(1, 3));
                3: begin word = 1016 + $urandom_range(0, 7); addr = 16'(word * 4); end
                default: ;
            endcase
            err = model_err(addr, len, size, burst);
            eresp = err ? 2'b10 : 2'b00;
            nexp = err ? 0 : len + 1;
            m0 = mem_log.size();
            if (is_wr) begin
                for (int b = 0; b <= len; b++) wdat[b] = $urandom;
                send_aw(addr, 8'(len), size, burst, ac);
                send_w(len, len, lc);
                get_b(resp, bc);
                checks++; if (resp !== eresp || bc !== lc + 1) begin failures++; $display("FAIL rnd%0d_wr_b: bresp=%b edge=%0d required %b edge=%0d", t, resp, bc, eresp, lc + 1); end
                checks++; if (mem_log.size() - m0 != nexp) begin failures++; $display("FAIL rnd%0d_wr_count: got %0d writes required %0d", t, mem_log.size() - m0, nexp); end
                else for (int b = 0; b < nexp; b++) begin
                    checks++;
                    if (mem_log[m0+b].we !== 1'b1 || mem_log[m0+b].addr != word + b || mem_log[m0+b].data !== wdat[b]) begin
                        failures++; $display("FAIL rnd%0d_wr_beat%0d: idx=%0d data=%h required idx=%0d data=%h", t, b, mem_log[m0+b].addr, mem_log[m0+b].data, word + b, wdat[b]);
                    end
                    exp_mem[word+b] = wdat[b];
                end
            end else begin
                send_ar(addr, 8'(len), size, burst);
                get_r(len, $urandom_range(0, len), $urandom_range(0, 3));
                for (int b = 0; b <= len; b++) begin
                    checks++;
                    if (got_data[b] !== (err ? 32'h0 : exp_mem[word+b]) || got_resp[b] !== eresp || got_last[b] !== (b == len)) begin
                        failures++; $display("FAIL rnd%0d_rd_beat%0d: data=%h resp=%b last=%b required data=%h resp=%b last=%b", t, b, got_data[b], got_resp[b], got_last[b], err ? 32'h0 : exp_mem[word+b], eresp, b == len);
                    end
                end
                checks++; if (mem_log.size() - m0 != nexp || stall_mem != 0 || stall_changed) begin failures++; $display("FAIL rnd%0d_rd_mem: strobes=%0d stall_strobes=%0d stall_changed=%b required %0d 0 0", t, mem_log.size() - m0, stall_mem, stall_changed, nexp); end
            end
        end
    endtask

    initial begin
        rst_n = 0;
        clear_inputs();
        test_reset();
        test_write_basic();
        test_read_basic();
        test_arbitration();
        test_error();
        test_wlast_err();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
